uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmit framer: the next-generation transmit engine for the UART cores. Adds programmable data length (5..DATA_MAX), five parity modes, one or two stop bits, break generation, optional line inversion and MSB-first ordering. Accepts bytes over a valid/ready handshake from a FIFO or holding register. Serialises them on a 1x baud tick from the shared baud generator.

## Interface
- DATA_MAX, 8: widest supported data length, legal 5..16.
- INVERT, 0: 1 inverts the tx pin; idle becomes low.
- LSB_FIRST, 1: 1 sends LSB first; 0 sends MSB of the active length first.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- baud_tick  in  1  one-clk pulse per bit period.
- tx_data  in  DATA_MAX  word to send; bits above data_len ignored.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  framer can accept a word.
- data_len  in  5  data bits per frame; <5 clamps to 5, >DATA_MAX clamps to DATA_MAX.
- parity_mode  in  3  000 none, 001 odd, 010 even, 011 mark (1), 100 space (0); 101-111 = none.
- stop_two  in  1  0: one stop bit, 1: two stop bits.
- brk  in  1  request break (line held at space).
- tx  out  1  serial line.
- busy  out  1  frame or break in progress.
- frame_done  out  1  one-clk pulse when the last stop bit is driven.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK. The state names the next bit to drive. All line updates occur only on baud_tick. The internal line value is line; tx = line ^ INVERT.
- IDLE: tx_ready = 1 if brk = 0, else 0 (combinational).
  - tx_valid & tx_ready at a clk edge → accept.
  - On accept: latch tx_data, clamped data_len, parity_mode and stop_two; state → START.
  - Config changes after accept have no effect on that frame.
- IDLE with brk = 1 → BREAK (on clk; no tick needed). brk mid-frame is ignored until the frame returns to IDLE.
- START, on tick: line ← 0; bit counter ← 0; → DATA.
- DATA, on tick:
  - line ← next data bit (LSB_FIRST order over latched length).
  - Parity accumulator XORs the driven bit; counter increments.
  - After data_len bits: → PARITY if mode ≠ none, else → STOP.
- PARITY, on tick: line ← parity bit, then → STOP.
  - odd: line = ~XOR(data). even: line = XOR(data).
  - mark: 1. space: 0.
- STOP, on tick: line ← 1.
  - After 1 tick (stop_two = 0) or 2 ticks (stop_two = 1): → IDLE and frame_done = 1 for that clk.
- BREAK, on tick: line ← 0 while brk = 1.
  - On the first tick with brk = 0: line ← 1, → IDLE.
- busy = (state ≠ IDLE).

## Timing
- Reset values: line = 1 (tx = ~INVERT? no: tx = INVERT ? 0 : 1), tx_ready = 1, busy = 0, frame_done = 0, state IDLE, all counters 0.
- reset_n asserted mid-frame aborts immediately and asynchronously; tx returns to idle level.
- Accept-to-start latency: the start bit is driven on the first baud_tick strictly after the accept edge. A tick coinciding with the accept edge does not start the frame.
- Frame length: 1 + data_len + (parity ? 1 : 0) + (stop_two ? 2 : 1) bit periods.
- frame_done coincides with the last stop tick.
- Back-to-back frames:
  - A word offered while IDLE is accepted the same clk (tx_ready combinational).
  - Its start bit follows the final stop bit by exactly one bit period.
  - There is no extra idle gap.
- Simultaneous brk = 1 and tx_valid in IDLE: break wins; tx_ready = 0; the word is not accepted.
- Between ticks, line holds its value; tx is glitch-free (registered output).

## Test plan
- Reset mid-frame:
  - Stimulus: send 0xA5 with len 8, no parity, 1 stop; assert reset_n low after the 3rd data bit.
  - Required: tx = 1 immediately, busy = 0, tx_ready = 1. A subsequent 0x3C frame is correct.
- 8N1 frame:
  - Stimulus: tx_data = 0x5A, len 8, parity none, stop_two = 0.
  - Required: line sequence at ticks 0,0,1,0,1,1,0,1,0,1 (start, LSB-first data, stop). frame_done pulses on tick 10. busy falls on the same clk.
- 7E2 and parity modes:
  - 0x41 with len 7, even: parity bit 0, 11 periods total.
  - Repeat with odd → 1, mark → 1, space → 0.
  - parity_mode = 110: no parity bit.
- Length clamp and MSB-first:
  - DATA_MAX = 9, LSB_FIRST = 0, len = 9, data 0x1A5: data bits 1,1,0,1,0,0,1,0,1.
  - len = 3 sends 5 bits; len = 15 sends 9 bits.
- Back-to-back:
  - tx_valid held high with 0x00 then 0xFF.
  - Required: second start bit exactly one period after the first frame's stop bit. Accepts occur on the same clk as each frame_done. No gap.
- Break:
  - brk asserted mid-frame: the frame completes intact, then tx = 0 from the next tick.
  - While brk = 1: tx_ready = 0 with tx_valid held.
  - brk released: tx = 1 on the next tick, then the pending word is accepted.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 5..DATA_MAX data bits, optional parity, 1 or 2 stop bits, break.
// The line only changes on baud_tick; a word offered in IDLE is accepted the same clk (tx_ready is combinational).
module uart_tx_frame #(
  parameter int DATA_MAX  = 8,
  parameter int INVERT    = 0,
  parameter int LSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                baud_tick,
  input  logic [DATA_MAX-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [4:0]          data_len,
  input  logic [2:0]          parity_mode,
  input  logic                stop_two,
  input  logic                brk,
  output logic                tx,
  output logic                busy,
  output logic                frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  localparam logic [4:0] LEN_MIN = 5'd5;
  localparam logic [4:0] LEN_MAX = 5'(DATA_MAX);

  state_t              state_q, state_d;
  logic [DATA_MAX-1:0] data_q, data_d;
  logic [4:0]          len_q, len_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2:0]          mode_q, mode_d;
  logic                two_q, two_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                par_q, par_d;
  logic                line_q, line_d;
  logic                done_q, done_d;

  logic [4:0] len_clamp;
  logic       accept;
  logic       has_par;
  logic       last_bit;
  logic       last_stop;
  logic       next_bit;

  always_comb begin
    if (data_len < LEN_MIN)      len_clamp = LEN_MIN;
    else if (data_len > LEN_MAX) len_clamp = LEN_MAX;
    else                         len_clamp = data_len;
  end

  assign accept    = tx_valid & tx_ready;
  assign has_par   = (mode_q >= 3'd1) && (mode_q <= 3'd4);
  assign last_bit  = (cnt_q == len_q - 5'd1);
  assign last_stop = ~two_q | stop_cnt_q;
  // The shift register is pre-aligned on accept so the next bit always sits at a fixed end.
  assign next_bit  = (LSB_FIRST != 0) ? data_q[0] : data_q[DATA_MAX-1];

  // State register and datapath flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      two_q      <= 1'b0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      line_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      two_q      <= two_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      line_q     <= line_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (brk)           state_d = S_BREAK;
        else if (tx_valid) state_d = S_START;
      end
      S_START:  if (baud_tick) state_d = S_DATA;
      S_DATA:   if (baud_tick && last_bit) state_d = has_par ? S_PARITY : S_STOP;
      S_PARITY: if (baud_tick) state_d = S_STOP;
      S_STOP:   if (baud_tick && last_stop) state_d = S_IDLE;
      S_BREAK:  if (baud_tick && !brk) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and line outputs
  always_comb begin
    data_d     = data_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    two_d      = two_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    line_d     = line_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d     = (LSB_FIRST != 0) ? tx_data : (tx_data << (LEN_MAX - len_clamp));
          len_d      = len_clamp;
          mode_d     = parity_mode;
          two_d      = stop_two;
          cnt_d      = '0;
          stop_cnt_d = 1'b0;
          par_d      = 1'b0;
        end
      end
      S_START: begin
        if (baud_tick) begin
          line_d = 1'b0;
          cnt_d  = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          line_d = next_bit;
          par_d  = par_q ^ next_bit;
          cnt_d  = cnt_q + 5'd1;
          data_d = (LSB_FIRST != 0) ? (data_q >> 1) : (data_q << 1);
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          case (mode_q)
            3'b001:  line_d = ~par_q;
            3'b010:  line_d = par_q;
            3'b011:  line_d = 1'b1;
            default: line_d = 1'b0;
          endcase
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          line_d = 1'b1;
          if (last_stop) done_d = 1'b1;
          else           stop_cnt_d = 1'b1;
        end
      end
      S_BREAK: begin
        if (baud_tick) line_d = ~brk;
      end
      default: ;
    endcase
  end

  assign tx_ready   = (state_q == S_IDLE) & ~brk;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = done_q;
  assign tx         = line_q ^ (INVERT != 0);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized bench for uart_tx_frame: expected bit sequences come from a frame model built
// from start/data/parity/stop rules; two instances cover LSB-first and inverted MSB-first variants.
module tb_uart_tx_frame;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       baud_tick;

  logic [7:0] d8_data;
  logic       d8_valid, d8_ready, d8_two, d8_brk, d8_tx, d8_busy, d8_done;
  logic [4:0] d8_len;
  logic [2:0] d8_mode;

  logic [8:0] d9_data;
  logic       d9_valid, d9_ready, d9_two, d9_brk, d9_tx, d9_busy, d9_done;
  logic [4:0] d9_len;
  logic [2:0] d9_mode;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_MAX(8), .INVERT(0), .LSB_FIRST(1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick),
    .tx_data(d8_data), .tx_valid(d8_valid), .tx_ready(d8_ready),
    .data_len(d8_len), .parity_mode(d8_mode), .stop_two(d8_two), .brk(d8_brk),
    .tx(d8_tx), .busy(d8_busy), .frame_done(d8_done)
  );

  uart_tx_frame #(.DATA_MAX(9), .INVERT(1), .LSB_FIRST(0)) u_dut9 (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick),
    .tx_data(d9_data), .tx_valid(d9_valid), .tx_ready(d9_ready),
    .data_len(d9_len), .parity_mode(d9_mode), .stop_two(d9_two), .brk(d9_brk),
    .tx(d9_tx), .busy(d9_busy), .frame_done(d9_done)
  );

  task automatic check(input string tag, input int got, input int want);
    vec_cnt++;
    if (got != want) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Reference frame: start, data in wire order, optional parity, stop bits.
  function automatic void model_frame(input int data, input int len, input int mode,
                                      input int two, input int dmax, input int lsb);
    int l, ones, idx, b;
    exp_q.delete();
    l = (len < 5) ? 5 : ((len > dmax) ? dmax : len);
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < l; i++) begin
      idx = (lsb != 0) ? i : (l - 1 - i);
      b = (data >> idx) & 1;
      ones += b;
      exp_q.push_back(b[0]);
    end
    case (mode)
      1: exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
      2: exp_q.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
      3: exp_q.push_back(1'b1);
      4: exp_q.push_back(1'b0);
      default: ;
    endcase
    exp_q.push_back(1'b1);
    if (two != 0) exp_q.push_back(1'b1);
  endfunction

  function automatic logic get_tx(input int sel);   return (sel != 0) ? d9_tx    : d8_tx;    endfunction
  function automatic logic get_busy(input int sel); return (sel != 0) ? d9_busy  : d8_busy;  endfunction
  function automatic logic get_done(input int sel); return (sel != 0) ? d9_done  : d8_done;  endfunction
  function automatic logic get_rdy(input int sel);  return (sel != 0) ? d9_ready : d8_ready; endfunction
  function automatic int   inv_of(input int sel);   return (sel != 0) ? 1 : 0;               endfunction

  task automatic set_in(input int sel, input logic [15:0] data, input logic [4:0] len,
                        input logic [2:0] mode, input logic two, input logic vld);
    if (sel != 0) begin
      d9_data = data[8:0]; d9_len = len; d9_mode = mode; d9_two = two; d9_valid = vld;
    end else begin
      d8_data = data[7:0]; d8_len = len; d8_mode = mode; d8_two = two; d8_valid = vld;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    baud_tick = 1'b1;
    step();
    baud_tick = 1'b0;
  endtask

  task automatic frame_ticks(input int sel, input int from, input int upto, input string tag);
    int last;
    last = exp_q.size() - 1;
    for (int i = from; i < upto; i++) begin
      repeat (GAP) step();
      tick();
      check($sformatf("%s_bit%0d", tag, i), int'(get_tx(sel)) ^ inv_of(sel), int'(exp_q[i]));
      check($sformatf("%s_done%0d", tag, i), int'(get_done(sel)), (i == last) ? 1 : 0);
      check($sformatf("%s_busy%0d", tag, i), int'(get_busy(sel)), (i == last) ? 0 : 1);
    end
  endtask

  // Offer a word, accept it, scramble the inputs, then walk up to n_ticks bit periods (-1 = whole frame).
  task automatic run_frame(input int sel, input int data, input int len, input int mode,
                           input int two, input int n_ticks, input bit coinc, input string tag);
    int n;
    model_frame(data, len, mode, two, (sel != 0) ? 9 : 8, (sel != 0) ? 0 : 1);
    set_in(sel, data[15:0], len[4:0], mode[2:0], two[0], 1'b1);
    check({tag, "_rdy"}, int'(get_rdy(sel)), 1);
    baud_tick = coinc;
    step();
    baud_tick = 1'b0;
    set_in(sel, 16'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), 1'b0);
    check({tag, "_busy_acc"}, int'(get_busy(sel)), 1);
    if (coinc) check({tag, "_no_early_start"}, int'(get_tx(sel)) ^ inv_of(sel), 1);
    n = (n_ticks >= 0 && n_ticks < exp_q.size()) ? n_ticks : exp_q.size();
    frame_ticks(sel, 0, n, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; baud_tick = 1'b0; d8_brk = 1'b0; d9_brk = 1'b0;
    set_in(0, 16'h0, 5'd8, 3'd0, 1'b0, 1'b0);
    set_in(1, 16'h0, 5'd9, 3'd0, 1'b0, 1'b0);
    repeat (3) step();
    check("rst_tx8", int'(d8_tx), 1);
    check("rst_tx9_inv", int'(d9_tx), 0);
    check("rst_busy", int'(d8_busy), 0);
    check("rst_rdy", int'(d8_ready), 1);
    check("rst_done", int'(d8_done), 0);
    reset_n = 1'b1;
    repeat (2) step();

    // Abort mid-frame after the third data bit, then a clean frame.
    run_frame(0, 'hA5, 8, 0, 0, 4, 1'b0, "rst_mid");
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_tx", int'(d8_tx), 1);
    check("rstmid_busy", int'(d8_busy), 0);
    check("rstmid_rdy", int'(d8_ready), 1);
    step();
    reset_n = 1'b1;
    step();
    run_frame(0, 'h3C, 8, 0, 0, -1, 1'b0, "post_rst");

    run_frame(0, 'h5A, 8, 0, 0, -1, 1'b0, "8n1");
    run_frame(0, 'h41, 7, 2, 1, -1, 1'b0, "7e2");
    check("7e2_len", exp_q.size(), 11);
    run_frame(0, 'h41, 7, 1, 1, -1, 1'b0, "7o2");
    run_frame(0, 'h41, 7, 3, 1, -1, 1'b0, "7m2");
    run_frame(0, 'h41, 7, 4, 1, -1, 1'b0, "7s2");
    run_frame(0, 'h41, 7, 6, 1, -1, 1'b0, "7x2");
    run_frame(0, 'hC3, 8, 2, 1, -1, 1'b1, "coinc");

    // MSB-first, inverted, clamped lengths.
    run_frame(1, 'h1A5, 9, 0, 0, -1, 1'b0, "msb9");
    run_frame(1, 'h1A5, 3, 0, 0, -1, 1'b0, "msb_len3");
    run_frame(1, 'h1A5, 15, 1, 0, -1, 1'b0, "msb_len15");

    for (int k = 0; k < 12; k++) begin
      run_frame(k % 2, int'($urandom_range(0, 65535)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), -1, 1'b0,
                $sformatf("rnd%0d", k));
    end

    // Back-to-back with tx_valid held high.
    model_frame('h00, 8, 0, 0, 8, 1);
    set_in(0, 16'h00, 5'd8, 3'd0, 1'b0, 1'b1);
    check("b2b_rdy0", int'(d8_ready), 1);
    step();
    d8_data = 8'hFF;
    frame_ticks(0, 0, exp_q.size(), "b2b_a");
    check("b2b_rdy_at_done", int'(d8_ready), 1);
    model_frame('hFF, 8, 0, 0, 8, 1);
    frame_ticks(0, 0, exp_q.size(), "b2b_b");
    d8_valid = 1'b0;

    // Break requested mid-frame, word held pending.
    run_frame(0, 'h96, 8, 0, 0, 3, 1'b0, "brk_a");
    d8_brk = 1'b1;
    set_in(0, 16'h33, 5'd8, 3'd1, 1'b0, 1'b1);
    frame_ticks(0, 3, exp_q.size(), "brk_frm");
    check("brk_rdy_done", int'(d8_ready), 0);
    for (int k = 0; k < 3; k++) begin
      repeat (GAP) step();
      tick();
      check($sformatf("brk_tx%0d", k), int'(d8_tx), 0);
      check($sformatf("brk_rdy%0d", k), int'(d8_ready), 0);
      check($sformatf("brk_busy%0d", k), int'(d8_busy), 1);
    end
    d8_brk = 1'b0;
    repeat (GAP) step();
    check("brk_held_rdy", int'(d8_ready), 0);
    tick();
    check("brk_rel_tx", int'(d8_tx), 1);
    check("brk_rel_busy", int'(d8_busy), 0);
    check("brk_rel_rdy", int'(d8_ready), 1);
    run_frame(0, 'h33, 8, 1, 0, -1, 1'b0, "brk_post");

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
